// File: rtl/lpf_sample_sequencer.sv
// Sequencer feeding a low-pass filter from a synchronous-read sample memory,
// appending zero flush samples and streaming captured results over valid/ready.
module lpf_sample_sequencer #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 7,
   parameter int NUM_SAMPLES   = 125,
   parameter int SAMPLE_DIV    = 4,
   parameter int FLUSH_SAMPLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] noisy_data,
   output logic              sample_valid,
   input  logic [DATA_W-1:0] filtered_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // state    | meaning
   // IDLE     | waiting for start
   // FETCH    | period cycle 0, memory read issued (memory samples only)
   // LOAD     | period cycle 1, read data (or zero) loaded into noisy_data
   // HOLD     | period cycles 2..SAMPLE_DIV-1, capture on the last one
   // WAIT_OUT | capture point reached but output slot still occupied
   // DRAIN    | last result captured, waiting for it to be accepted

   localparam int TOTAL = NUM_SAMPLES + FLUSH_SAMPLES;
   localparam int IDX_W = $clog2(TOTAL) + 1;
   localparam int CNT_W = $clog2(SAMPLE_DIV);

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TOTAL - 1);
   localparam logic [IDX_W-1:0] IDX_NMEM  = IDX_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(SAMPLE_DIV - 3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_HOLD,
      S_WAIT_OUT,
      S_DRAIN
   } state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  hold_cnt;
   logic [ADDR_W-1:0] addr_idx;

   logic slot_free, is_mem, kill;
   logic capture, idx_clr, idx_inc, load_smp, cnt_load, cnt_dec, finish;

   if (IDX_W >= ADDR_W) begin : g_addr_trunc
      assign addr_idx = idx[ADDR_W-1:0];
   end else begin : g_addr_ext
      assign addr_idx = {{(ADDR_W-IDX_W){1'b0}}, idx};
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      load_smp  = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      finish    = 1'b0;
      slot_free = !out_valid || out_ready;
      is_mem    = idx < IDX_NMEM;
      busy      = state != S_IDLE;
      kill      = abort && busy;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               idx_clr   = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_LOAD;
         S_LOAD: begin
            load_smp  = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (hold_cnt != '0)  cnt_dec   = 1'b1;
            else if (slot_free)  capture   = 1'b1;
            else                 state_nxt = S_WAIT_OUT;
         end
         S_WAIT_OUT: begin
            if (slot_free) capture = 1'b1;
         end
         S_DRAIN: begin
            if (out_valid && out_ready) begin
               finish    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (capture) begin
         if (idx == IDX_LAST) begin
            state_nxt = S_DRAIN;
         end else begin
            idx_inc   = 1'b1;
            state_nxt = S_FETCH;
         end
      end

      // Abort wins over everything, including a capture in the same cycle.
      if (kill) begin
         state_nxt = S_IDLE;
         capture   = 1'b0;
         idx_inc   = 1'b0;
         load_smp  = 1'b0;
         finish    = 1'b0;
      end

      mem_rd_en = (state == S_FETCH) && is_mem;
      mem_addr  = mem_rd_en ? addr_idx : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx          <= '0;
         hold_cnt     <= '0;
         noisy_data   <= '0;
         sample_valid <= 1'b0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         done         <= 1'b0;
      end else if (kill) begin
         idx          <= '0;
         hold_cnt     <= '0;
         noisy_data   <= '0;
         sample_valid <= 1'b0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         done         <= 1'b0;
      end else begin
         sample_valid <= load_smp;
         done         <= finish;

         if (idx_clr)      idx <= '0;
         else if (idx_inc) idx <= idx + IDX_W'(1);

         if (load_smp) noisy_data <= is_mem ? mem_rdata : '0;

         if (cnt_load)     hold_cnt <= HOLD_INIT;
         else if (cnt_dec) hold_cnt <= hold_cnt - CNT_W'(1);

         // A capture refills the slot even when the old result leaves this cycle.
         if (capture) begin
            out_data  <= filtered_data;
            out_valid <= 1'b1;
            out_last  <= idx == IDX_LAST;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lpf_sample_sequencer.sv
// Directed bench for lpf_sample_sequencer: one instance with two flush samples,
// one with none; the filter is modelled as noisy_data + 0x100.
module tb_lpf_sample_sequencer;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          chk_cnt = 0;
   int          err_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] rom [128];

   // instance with FLUSH_SAMPLES=2
   logic        reset, start, abort, out_ready;
   logic [6:0]  mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata = '0;
   logic [31:0] noisy_data, filtered_data, out_data;
   logic        sample_valid, out_valid, out_last, busy, done;

   // instance with FLUSH_SAMPLES=0
   logic        reset_f0, start_f0, abort_f0, out_ready_f0;
   logic [6:0]  mem_addr_f0;
   logic        mem_rd_en_f0;
   logic [31:0] mem_rdata_f0 = '0;
   logic [31:0] noisy_data_f0, filtered_data_f0, out_data_f0;
   logic        sample_valid_f0, out_valid_f0, out_last_f0, busy_f0, done_f0;

   lpf_sample_sequencer #(.DATA_W(32), .ADDR_W(7), .NUM_SAMPLES(4),
                          .SAMPLE_DIV(4), .FLUSH_SAMPLES(2)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .noisy_data(noisy_data), .sample_valid(sample_valid),
      .filtered_data(filtered_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
   );

   lpf_sample_sequencer #(.DATA_W(32), .ADDR_W(7), .NUM_SAMPLES(4),
                          .SAMPLE_DIV(4), .FLUSH_SAMPLES(0)) dut_f0 (
      .clk(clk), .reset(reset_f0), .start(start_f0), .abort(abort_f0),
      .mem_addr(mem_addr_f0), .mem_rd_en(mem_rd_en_f0), .mem_rdata(mem_rdata_f0),
      .noisy_data(noisy_data_f0), .sample_valid(sample_valid_f0),
      .filtered_data(filtered_data_f0), .out_data(out_data_f0),
      .out_valid(out_valid_f0), .out_ready(out_ready_f0), .out_last(out_last_f0),
      .busy(busy_f0), .done(done_f0)
   );

   assign filtered_data    = noisy_data + 32'h100;
   assign filtered_data_f0 = noisy_data_f0 + 32'h100;

   always @(posedge clk) if (mem_rd_en)    mem_rdata    <= rom[mem_addr];
   always @(posedge clk) if (mem_rd_en_f0) mem_rdata_f0 <= rom[mem_addr_f0];

   // monitors
   logic [31:0] out_q[$], smp_q[$], addr_q[$];
   logic        last_q[$];
   int          rd_cyc_q[$];
   int          done_cnt = 0;
   logic [31:0] out_q_f0[$], smp_q_f0[$];
   logic        last_q_f0[$];
   int          done_cnt_f0 = 0;
   int          zero_mid_f0 = 0;
   logic        seen_smp_f0 = 1'b0;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         out_q.push_back(out_data);
         last_q.push_back(out_last);
      end
      if (sample_valid) smp_q.push_back(noisy_data);
      if (mem_rd_en) begin
         addr_q.push_back({25'd0, mem_addr});
         rd_cyc_q.push_back(cyc);
      end
      if (done) done_cnt++;
   end

   always @(negedge clk) begin
      if (out_valid_f0 && out_ready_f0) begin
         out_q_f0.push_back(out_data_f0);
         last_q_f0.push_back(out_last_f0);
      end
      if (sample_valid_f0) begin
         smp_q_f0.push_back(noisy_data_f0);
         seen_smp_f0 = 1'b1;
      end
      if (busy_f0 && seen_smp_f0 && noisy_data_f0 == 32'd0) zero_mid_f0++;
      if (done_f0) done_cnt_f0++;
   end

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      chk_cnt++;
      if (obs !== exp_v) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      out_q.delete(); last_q.delete(); smp_q.delete();
      addr_q.delete(); rd_cyc_q.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk_val("done_wait", 32'(done_cnt > 0), 32'd1);
      tick();
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] exp_out [6] = '{32'h110, 32'h120, 32'h130, 32'h140, 32'h100, 32'h100};
      chk_val({tag, "_out_count"}, 32'(out_q.size()), 32'd6);
      for (int i = 0; i < 6 && i < out_q.size(); i++) begin
         chk_val($sformatf("%s_out%0d", tag, i), out_q[i], exp_out[i]);
         chk_val($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == 5));
      end
   endtask

   initial begin
      logic [31:0] exp_smp [6] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h0, 32'h0};

      for (int i = 0; i < 128; i++) rom[i] = 32'hDEAD0000 | 32'(i);
      rom[0] = 32'h10; rom[1] = 32'h20; rom[2] = 32'h30; rom[3] = 32'h40;

      reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      reset_f0 = 1'b0; start_f0 = 1'b0; abort_f0 = 1'b0; out_ready_f0 = 1'b1;
      tick(3);

      chk_val("rst_busy", 32'(busy), 32'd0);
      chk_val("rst_out_valid", 32'(out_valid), 32'd0);
      chk_val("rst_noisy", noisy_data, 32'd0);
      chk_val("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk_val("rst_addr", 32'(mem_addr), 32'd0);
      chk_val("rst_done", 32'(done), 32'd0);
      chk_val("rst_last", 32'(out_last), 32'd0);
      reset = 1'b1; reset_f0 = 1'b1;
      tick(2);

      // basic run
      clear_mon();
      pulse_start();
      chk_val("basic_busy", 32'(busy), 32'd1);
      wait_done(100);
      chk_val("basic_addr_count", 32'(addr_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
         chk_val($sformatf("basic_addr%0d", i), addr_q[i], 32'(i));
         if (i > 0) chk_val($sformatf("basic_addr_gap%0d", i),
                            32'(rd_cyc_q[i] - rd_cyc_q[i-1]), 32'd4);
      end
      chk_val("basic_smp_count", 32'(smp_q.size()), 32'd6);
      for (int i = 0; i < 6 && i < smp_q.size(); i++)
         chk_val($sformatf("basic_smp%0d", i), smp_q[i], exp_smp[i]);
      check_outputs("basic");
      tick(5);
      chk_val("basic_done_count", 32'(done_cnt), 32'd1);
      chk_val("basic_busy_end", 32'(busy), 32'd0);

      // backpressure after first capture
      clear_mon();
      pulse_start();
      begin
         int n = 0;
         while (!out_valid && n < 20) begin tick(); n++; end
      end
      chk_val("bp_first_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk_val($sformatf("bp_hold_data%0d", i), out_data, 32'h110);
         chk_val($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
         if (i >= 4) begin
            chk_val($sformatf("bp_wait_noisy%0d", i), noisy_data, 32'h20);
            chk_val($sformatf("bp_wait_rd%0d", i), 32'(mem_rd_en), 32'd0);
         end
         tick();
      end
      out_ready = 1'b1;
      wait_done(100);
      check_outputs("bp");
      chk_val("bp_done_count", 32'(done_cnt), 32'd1);

      // start while busy
      clear_mon();
      tick(2);
      pulse_start();
      tick(8);
      pulse_start();
      wait_done(100);
      tick(30);
      check_outputs("restart");
      chk_val("restart_done_count", 32'(done_cnt), 32'd1);
      chk_val("restart_busy_end", 32'(busy), 32'd0);

      // abort on the capture cycle of sample 2
      clear_mon();
      pulse_start();
      tick(10);
      chk_val("abort_pre_noisy_a", noisy_data, 32'h30);
      tick();
      chk_val("abort_pre_noisy_b", noisy_data, 32'h30);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_val("abort_busy", 32'(busy), 32'd0);
      chk_val("abort_out_valid", 32'(out_valid), 32'd0);
      chk_val("abort_noisy", noisy_data, 32'd0);
      chk_val("abort_last", 32'(out_last), 32'd0);
      chk_val("abort_rd_en", 32'(mem_rd_en), 32'd0);
      tick(10);
      chk_val("abort_no_done", 32'(done_cnt), 32'd0);
      chk_val("abort_out_count", 32'(out_q.size()), 32'd2);
      clear_mon();
      pulse_start();
      chk_val("abort_restart_rd", 32'(mem_rd_en), 32'd1);
      chk_val("abort_restart_addr", 32'(mem_addr), 32'd0);
      wait_done(100);
      check_outputs("abort_rerun");

      // reset while waiting for output slot
      clear_mon();
      out_ready = 1'b0;
      tick(2);
      pulse_start();
      tick(9);
      chk_val("rst_mid_busy_pre", 32'(busy), 32'd1);
      chk_val("rst_mid_valid_pre", 32'(out_valid), 32'd1);
      chk_val("rst_mid_data_pre", out_data, 32'h110);
      chk_val("rst_mid_noisy_pre", noisy_data, 32'h20);
      chk_val("rst_mid_rd_pre", 32'(mem_rd_en), 32'd0);
      reset = 1'b0;
      #2;
      chk_val("rst_mid_sync_busy", 32'(busy), 32'd1);
      chk_val("rst_mid_sync_valid", 32'(out_valid), 32'd1);
      tick();
      chk_val("rst_mid_busy", 32'(busy), 32'd0);
      chk_val("rst_mid_valid", 32'(out_valid), 32'd0);
      chk_val("rst_mid_data", out_data, 32'd0);
      chk_val("rst_mid_noisy", noisy_data, 32'd0);
      chk_val("rst_mid_last", 32'(out_last), 32'd0);
      chk_val("rst_mid_sv", 32'(sample_valid), 32'd0);
      chk_val("rst_mid_addr", 32'(mem_addr), 32'd0);
      reset = 1'b1;
      out_ready = 1'b1;
      tick(20);
      chk_val("rst_mid_no_out", 32'(out_q.size()), 32'd0);
      chk_val("rst_mid_no_done", 32'(done_cnt), 32'd0);
      chk_val("rst_mid_idle", 32'(busy), 32'd0);

      // no flush samples
      start_f0 = 1'b1;
      tick();
      start_f0 = 1'b0;
      begin
         int n = 0;
         while (done_cnt_f0 == 0 && n < 100) begin @(negedge clk); n++; end
      end
      chk_val("f0_done_wait", 32'(done_cnt_f0 > 0), 32'd1);
      tick(5);
      chk_val("f0_out_count", 32'(out_q_f0.size()), 32'd4);
      for (int i = 0; i < 4 && i < out_q_f0.size(); i++) begin
         chk_val($sformatf("f0_out%0d", i), out_q_f0[i], 32'h110 + 32'(i) * 32'h10);
         chk_val($sformatf("f0_last%0d", i), 32'(last_q_f0[i]), 32'(i == 3));
      end
      chk_val("f0_smp_count", 32'(smp_q_f0.size()), 32'd4);
      for (int i = 0; i < 4 && i < smp_q_f0.size(); i++)
         chk_val($sformatf("f0_smp%0d", i), smp_q_f0[i], 32'h10 + 32'(i) * 32'h10);
      chk_val("f0_no_zero_mid", 32'(zero_mid_f0), 32'd0);
      chk_val("f0_done_count", 32'(done_cnt_f0), 32'd1);
      chk_val("f0_busy_end", 32'(busy_f0), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
